// File: rtl/sha_nonce_scheduler.sv
// rtl/sha_nonce_scheduler.sv - demand-driven nonce dispatch and result write-back for a bank of hash cores
module sha_nonce_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int NUM_NONCES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             hash_out_addr,
  output logic                    done,
  output logic                    err,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [31:0]             core_nonce,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES*32-1:0] core_hash,
  output logic                    mem_we,
  output logic [15:0]             memory_addr,
  output logic [31:0]             memory_write_data
);

  localparam int             CW          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [8:0]     NONCE_LIMIT = 9'(NUM_NONCES);
  localparam logic [CW:0]    CORE_COUNT  = (CW+1)'(NUM_CORES);
  localparam logic [CW-1:0]  LAST_CORE   = CW'(NUM_CORES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t state, state_next;

  logic [NUM_CORES-1:0] busy, busy_n;
  logic [NUM_CORES-1:0] slot_valid, valid_n;
  logic [7:0]           slot_tag [NUM_CORES];
  logic [7:0]           tag_n    [NUM_CORES];
  logic [31:0]          slot_data [NUM_CORES];
  logic [31:0]          data_n    [NUM_CORES];
  logic [8:0]           issued, issued_n, issued_base;
  logic [CW-1:0]        rr_ptr, rr_n;
  logic [15:0]          base_addr, base_n;

  logic                 done_n, err_n, mem_we_n;
  logic [NUM_CORES-1:0] core_start_n;
  logic [31:0]          core_nonce_n, wdata_n;
  logic [15:0]          addr_n;

  logic                 start_ok, run_en, dispatch_en;
  logic                 disp_hit, grant_hit;
  logic [CW-1:0]        grant_idx;
  logic [CW:0]          rr_sum;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state: leave RUN at the edge that retires the last outstanding slot
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN:  if (issued_n == NONCE_LIMIT && busy_n == '0 && valid_n == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output/datapath decisions: write grant, result capture, core dispatch
  always_comb begin
    start_ok     = (state == S_IDLE) && start;
    run_en       = (state == S_RUN);
    issued_base  = start_ok ? 9'd0 : issued;
    busy_n       = busy;
    valid_n      = slot_valid;
    tag_n        = slot_tag;
    data_n       = slot_data;
    issued_n     = issued_base;
    err_n        = start_ok ? 1'b0 : err;
    rr_n         = start_ok ? '0 : rr_ptr;
    base_n       = start_ok ? hash_out_addr : base_addr;
    core_start_n = '0;
    core_nonce_n = '0;
    mem_we_n     = 1'b0;
    addr_n       = memory_addr;
    wdata_n      = memory_write_data;
    grant_hit    = 1'b0;
    grant_idx    = '0;
    rr_sum       = '0;
    disp_hit     = 1'b0;

    // round-robin search over valid slots starting at the pointer
    for (int k = 0; k < NUM_CORES; k++) begin
      rr_sum = {1'b0, rr_ptr} + (CW+1)'(k);
      if (rr_sum >= CORE_COUNT) rr_sum = rr_sum - CORE_COUNT;
      if (!grant_hit && slot_valid[rr_sum[CW-1:0]]) begin
        grant_hit = 1'b1;
        grant_idx = rr_sum[CW-1:0];
      end
    end

    if (run_en && grant_hit) begin
      mem_we_n           = 1'b1;
      addr_n             = base_addr + {8'd0, slot_tag[grant_idx]};
      wdata_n            = slot_data[grant_idx];
      valid_n[grant_idx] = 1'b0;
      busy_n[grant_idx]  = 1'b0;
      rr_n               = (grant_idx == LAST_CORE) ? '0 : grant_idx + 1'b1;
    end

    // a done pulse is only legal from a busy core whose slot is still empty
    if (run_en) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_done[i]) begin
          if (busy[i] && !slot_valid[i]) begin
            valid_n[i] = 1'b1;
            data_n[i]  = core_hash[i*32 +: 32];
          end else begin
            err_n = 1'b1;
          end
        end
      end
    end

    // the accepted start edge already issues nonce 0, so it shows one cycle later
    dispatch_en = (run_en || start_ok) && (issued_base < NONCE_LIMIT);
    if (dispatch_en) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!disp_hit && !busy[i]) begin
          disp_hit        = 1'b1;
          core_start_n[i] = 1'b1;
          core_nonce_n    = {23'd0, issued_base};
          busy_n[i]       = 1'b1;
          tag_n[i]        = issued_base[7:0];
        end
      end
    end
    if (disp_hit) issued_n = issued_base + 9'd1;

    done_n = (state_next == S_IDLE);
  end

  // Registered outputs and per-core bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      done              <= 1'b1;
      err               <= 1'b0;
      core_start        <= '0;
      core_nonce        <= '0;
      mem_we            <= 1'b0;
      memory_addr       <= '0;
      memory_write_data <= '0;
      busy              <= '0;
      slot_valid        <= '0;
      issued            <= '0;
      rr_ptr            <= '0;
      base_addr         <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_tag[i]  <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      done              <= done_n;
      err               <= err_n;
      core_start        <= core_start_n;
      core_nonce        <= core_nonce_n;
      mem_we            <= mem_we_n;
      memory_addr       <= addr_n;
      memory_write_data <= wdata_n;
      busy              <= busy_n;
      slot_valid        <= valid_n;
      issued            <= issued_n;
      rr_ptr            <= rr_n;
      base_addr         <= base_n;
      slot_tag          <= tag_n;
      slot_data         <= data_n;
    end
  end

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// tb/tb_sha_nonce_scheduler.sv - scoreboard bench for sha_nonce_scheduler
module tb_sha_nonce_scheduler;
  localparam int NC = 4;
  localparam int NN = 16;

  logic             clk = 1'b0;
  logic             reset, start;
  logic [15:0]      hash_out_addr;
  logic             done, err;
  logic [NC-1:0]    core_start;
  logic [31:0]      core_nonce;
  logic [NC-1:0]    core_done;
  logic [NC*32-1:0] core_hash;
  logic             mem_we;
  logic [15:0]      memory_addr;
  logic [31:0]      memory_write_data;

  always #5 clk = ~clk;

  sha_nonce_scheduler #(.NUM_CORES(NC), .NUM_NONCES(NN)) dut (
    .clk(clk), .reset(reset), .start(start), .hash_out_addr(hash_out_addr),
    .done(done), .err(err), .core_start(core_start), .core_nonce(core_nonce),
    .core_done(core_done), .core_hash(core_hash), .mem_we(mem_we),
    .memory_addr(memory_addr), .memory_write_data(memory_write_data)
  );

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          nonce;
    int          core;
    int          dcyc;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp, n_bad;
  int            cyc;
  int            lat [NC];
  int            cnt [NC];
  int            nonce_of [NC];
  logic          manual, check_lat, inject_arm;
  logic [NC-1:0] man_req, raw_req, free_tb, outstanding;
  logic [15:0]   base_tb;
  int            exp_issue, wr_count, last_wr_cyc;
  logic [NN-1:0] seen;
  logic [15:0]   addr_seen [NN];
  int            wr_core [64];
  int            wr_cyc  [64];

  function automatic logic [31:0] hash_of(input int n);
    return 32'(n) * 32'h01010101;
  endfunction

  // one clock: core models answer, dispatches and writes are scored at the falling edge
  task automatic tick();
    logic [NC-1:0] cd;
    logic          fire;
    int            sc, ec, hit;
    exp_t          e;
    @(negedge clk);
    cyc++;
    cd = '0;
    for (int i = 0; i < NC; i++) begin
      if (outstanding[i]) begin
        if (manual) fire = man_req[i];
        else begin
          cnt[i]--;
          fire = (cnt[i] <= 0);
        end
        if (fire) begin
          cd[i] = 1'b1;
          outstanding[i] = 1'b0;
          e.addr = base_tb + 16'(nonce_of[i]);
          e.data = hash_of(nonce_of[i]);
          e.nonce = nonce_of[i];
          e.core = i;
          e.dcyc = cyc;
          sb.push_back(e);
        end
      end
    end
    man_req = '0;
    if (core_start != '0) begin
      sc = -1;
      ec = -1;
      for (int i = 0; i < NC; i++) begin
        if (core_start[i] && sc < 0) sc = i;
        if (free_tb[i] && ec < 0) ec = i;
      end
      n_cmp++;
      if (sc != ec || $countones(core_start) != 1) begin
        n_bad++;
        $display("FAIL dispatch_core cyc=%0d got core_start=%b want core %0d", cyc, core_start, ec);
      end
      n_cmp++;
      if (core_nonce !== 32'(exp_issue)) begin
        n_bad++;
        $display("FAIL dispatch_nonce cyc=%0d got %0d want %0d", cyc, core_nonce, exp_issue);
      end
      if (sc >= 0) begin
        free_tb[sc] = 1'b0;
        outstanding[sc] = 1'b1;
        nonce_of[sc] = exp_issue;
        cnt[sc] = lat[sc];
      end
      exp_issue++;
    end
    if (mem_we === 1'b1) begin
      hit = -1;
      for (int k = 0; k < sb.size(); k++)
        if (hit < 0 && sb[k].addr == memory_addr) hit = k;
      n_cmp++;
      if (hit < 0) begin
        n_bad++;
        $display("FAIL write_addr cyc=%0d got unexpected addr %h", cyc, memory_addr);
      end else begin
        e = sb[hit];
        sb.delete(hit);
        n_cmp++;
        if (memory_write_data !== e.data) begin
          n_bad++;
          $display("FAIL write_data nonce=%0d got %h want %h", e.nonce, memory_write_data, e.data);
        end
        if (check_lat) begin
          n_cmp++;
          if (cyc - e.dcyc != 2) begin
            n_bad++;
            $display("FAIL write_latency nonce=%0d got %0d want 2", e.nonce, cyc - e.dcyc);
          end
        end
        seen[e.nonce] = 1'b1;
        addr_seen[e.nonce] = memory_addr;
        free_tb[e.core] = 1'b1;
        if (wr_count < 64) begin
          wr_core[wr_count] = e.core;
          wr_cyc[wr_count] = cyc;
        end
        wr_count++;
        last_wr_cyc = cyc;
        if (inject_arm && e.core == 2) begin
          cd[2] = 1'b1;
          inject_arm = 1'b0;
        end
      end
    end
    core_done = cd | raw_req;
    raw_req = '0;
    for (int i = 0; i < NC; i++) core_hash[i*32 +: 32] = hash_of(nonce_of[i]);
  endtask

  task automatic begin_run(input logic [15:0] base, input logic mnl, input int l0, input int l1,
                           input int l2, input int l3);
    base_tb = base;
    hash_out_addr = base;
    manual = mnl;
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    sb.delete();
    free_tb = '1;
    outstanding = '0;
    exp_issue = 0;
    wr_count = 0;
    last_wr_cyc = 0;
    seen = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_run(input logic exp_err);
    int t = 0;
    while (done !== 1'b1 && t < 3000) begin
      tick();
      t++;
    end
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL run_timeout got done=%b want 1", done); end
    n_cmp++;
    if (wr_count != NN) begin n_bad++; $display("FAIL write_count got %0d want %0d", wr_count, NN); end
    n_cmp++;
    if (seen !== '1) begin n_bad++; $display("FAIL nonces_written got %b want all ones", seen); end
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL pending_results got %0d want 0", sb.size()); end
    n_cmp++;
    if (err !== exp_err) begin n_bad++; $display("FAIL err_at_end got %b want %b", err, exp_err); end
    n_cmp++;
    if (cyc - last_wr_cyc > 1 || cyc < last_wr_cyc) begin
      n_bad++;
      $display("FAIL done_after_last_write got gap %0d want 0..1", cyc - last_wr_cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0 || core_start !== '0 || core_nonce !== '0 || mem_we !== 1'b0 ||
        memory_addr !== '0 || memory_write_data !== '0) begin
      n_bad++;
      $display("FAIL reset_values got done=%b err=%b cs=%b cn=%h we=%b a=%h d=%h want 1 0 0 0 0 0 0",
               done, err, core_start, core_nonce, mem_we, memory_addr, memory_write_data);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (done !== 1'b1 || core_start !== '0) begin
      n_bad++;
      $display("FAIL idle_after_reset got done=%b cs=%b want 1 0", done, core_start);
    end
  endtask

  task automatic test_basic();
    begin_run(16'h0100, 1'b0, 10, 10, 10, 10);
    n_cmp++;
    if (core_start !== 4'b0001 || core_nonce !== 32'd0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL first_dispatch got cs=%b nonce=%0d done=%b want 0001 0 0", core_start, core_nonce, done);
    end
    check_lat = 1'b1;
    finish_run(1'b0);
    check_lat = 1'b0;
  endtask

  task automatic test_simultaneous();
    int t;
    begin_run(16'h0400, 1'b1, 1, 1, 1, 1);
    for (int k = 0; k < 5; k++) tick();
    man_req = '1;
    t = 0;
    while (wr_count < 4 && t < 50) begin tick(); t++; end
    n_cmp++;
    if (wr_core[0] != 0 || wr_core[1] != 1 || wr_core[2] != 2 || wr_core[3] != 3 || wr_cyc[3] - wr_cyc[0] != 3) begin
      n_bad++;
      $display("FAIL burst1_order got %0d%0d%0d%0d span %0d want 0123 span 3",
               wr_core[0], wr_core[1], wr_core[2], wr_core[3], wr_cyc[3] - wr_cyc[0]);
    end
    for (int k = 0; k < 6; k++) tick();
    man_req = 4'b0001;
    t = 0;
    while (wr_count < 5 && t < 50) begin tick(); t++; end
    man_req = 4'b0010;
    t = 0;
    while (wr_count < 6 && t < 50) begin tick(); t++; end
    for (int k = 0; k < 6; k++) tick();
    man_req = '1;
    t = 0;
    while (wr_count < 10 && t < 50) begin tick(); t++; end
    n_cmp++;
    if (wr_core[6] != 2 || wr_core[7] != 3 || wr_core[8] != 0 || wr_core[9] != 1 || wr_cyc[9] - wr_cyc[6] != 3) begin
      n_bad++;
      $display("FAIL burst2_order got %0d%0d%0d%0d span %0d want 2301 span 3",
               wr_core[6], wr_core[7], wr_core[8], wr_core[9], wr_cyc[9] - wr_cyc[6]);
    end
    t = 0;
    while (done !== 1'b1 && t < 500) begin
      man_req = outstanding;
      tick();
      t++;
    end
    finish_run(1'b0);
  endtask

  task automatic test_wrap_skew();
    begin_run(16'hFFFE, 1'b0, 5, 17, 9, 30);
    finish_run(1'b0);
    n_cmp++;
    if (addr_seen[2] !== 16'h0000 || addr_seen[1] !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL wrap_addr got n1=%h n2=%h want FFFF 0000", addr_seen[1], addr_seen[2]);
    end
  endtask

  task automatic test_protocol_error();
    int t = 0;
    begin_run(16'h0800, 1'b0, 10, 10, 10, 10);
    inject_arm = 1'b1;
    while (inject_arm && t < 500) begin tick(); t++; end
    tick();
    tick();
    n_cmp++;
    if (err !== 1'b1 || inject_arm) begin
      n_bad++;
      $display("FAIL err_set got err=%b armed=%b want 1 0", err, inject_arm);
    end
    finish_run(1'b1);
  endtask

  task automatic test_reset_midrun();
    int t = 0;
    begin_run(16'h0A00, 1'b0, 7, 7, 7, 7);
    while (wr_count < 5 && t < 500) begin tick(); t++; end
    reset = 1'b1;
    core_done = '0;
    sb.delete();
    outstanding = '0;
    raw_req = 4'b0010;
    tick();
    n_cmp++;
    if (done !== 1'b1 || mem_we !== 1'b0 || core_start !== '0) begin
      n_bad++;
      $display("FAIL midrun_reset got done=%b we=%b cs=%b want 1 0 0", done, mem_we, core_start);
    end
    reset = 1'b0;
    tick();
    raw_req = 4'b0100;
    tick();
    tick();
    tick();
    n_cmp++;
    if (err !== 1'b0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL stale_done got err=%b done=%b want 0 1", err, done);
    end
    begin_run(16'h0A00, 1'b0, 7, 7, 7, 7);
    finish_run(1'b0);
  endtask

  task automatic test_start_while_busy();
    begin_run(16'h0200, 1'b0, 6, 11, 8, 13);
    for (int k = 0; k < 20; k++) tick();
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL still_running got done=%b want 0", done); end
    hash_out_addr = 16'h0300;
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_run(1'b0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    reset = 1'b1; start = 1'b0; hash_out_addr = '0;
    core_done = '0; core_hash = '0;
    manual = 1'b0; check_lat = 1'b0; inject_arm = 1'b0;
    man_req = '0; raw_req = '0; free_tb = '1; outstanding = '0;
    base_tb = '0; exp_issue = 0; wr_count = 0; last_wr_cyc = 0; seen = '0;
    for (int i = 0; i < NC; i++) begin lat[i] = 1; cnt[i] = 0; nonce_of[i] = 0; end
    for (int i = 0; i < NN; i++) addr_seen[i] = '0;
    test_reset();
    test_basic();
    test_simultaneous();
    test_wrap_skew();
    test_protocol_error();
    test_reset_midrun();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
